// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment codes are active-low, bit 0 = a through bit 6 = g.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_CODES [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decoder.sv
// Hex nibble to active-low seven-segment decoder.
// The blank input forces all segments off.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_CODES[i_nibble];
    if (i_blank) o_seg = 7'h7F;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller with dead-time blanking and
// frame-aligned commit of new display values through a valid/ready handshake.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  segmentDisplay,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam int            CW         = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  scan_state_t                  r_state_p0, w_state_nxt;
  logic [CW-1:0]                r_cnt_p0, w_cnt_nxt;
  logic [1:0]                   r_idx_p0, w_idx_nxt;
  logic                         w_frame_end_p0;

  logic [4*NUM_DIGITS-1:0]      r_disp_dig, r_pend_dig;
  logic [NUM_DIGITS-1:0]        r_disp_dp, r_pend_dp;
  logic                         r_disp_lz, r_pend_lz;
  logic                         r_pend_full;
  logic                         w_xfer;

  logic [3:0]                   w_nibble;
  logic [NUM_DIGITS-1:0]        w_lzmask;
  logic [6:0]                   w_seg;

  logic [3:0]                   r_an_p1;
  logic [6:0]                   r_seg_p1;
  logic                         r_dp_p1;
  logic                         r_fs_p1;
  logic                         r_fend_p1;

  // Stage p0: slot position of the cycle about to be shown on the pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state_p0 <= BLANK;
      r_cnt_p0   <= '0;
      r_idx_p0   <= '0;
    end else begin
      r_state_p0 <= w_state_nxt;
      r_cnt_p0   <= w_cnt_nxt;
      r_idx_p0   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state_p0;
    w_cnt_nxt      = r_cnt_p0 + CW'(1);
    w_idx_nxt      = r_idx_p0;
    w_frame_end_p0 = 1'b0;
    case (r_state_p0)
      BLANK: begin
        if (r_cnt_p0 == BLANK_LAST) begin
          w_state_nxt = DRIVE;
          w_cnt_nxt   = '0;
        end
      end
      DRIVE: begin
        if (r_cnt_p0 == DRIVE_LAST) begin
          w_state_nxt    = BLANK;
          w_cnt_nxt      = '0;
          w_idx_nxt      = r_idx_p0 + 2'd1;
          w_frame_end_p0 = (r_idx_p0 == 2'd3);
        end
      end
      default: begin
        w_state_nxt = BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_lzmask[3] = r_disp_lz && (r_disp_dig[15:12] == 4'h0);
  assign w_lzmask[2] = w_lzmask[3] && (r_disp_dig[11:8] == 4'h0);
  assign w_lzmask[1] = w_lzmask[2] && (r_disp_dig[7:4] == 4'h0);
  assign w_lzmask[0] = 1'b0;
  assign w_nibble    = r_disp_dig[{r_idx_p0, 2'b00} +: 4];

  seg_decoder u_dec (
    .i_nibble (w_nibble),
    .i_blank  (w_lzmask[r_idx_p0]),
    .o_seg    (w_seg)
  );

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an_p1   <= 4'hF;
      r_seg_p1  <= 7'h7F;
      r_dp_p1   <= 1'b1;
      r_fs_p1   <= 1'b0;
      r_fend_p1 <= 1'b0;
    end else begin
      r_fs_p1   <= (r_state_p0 == BLANK) && (r_cnt_p0 == '0) && (r_idx_p0 == 2'd0);
      r_fend_p1 <= w_frame_end_p0;
      if (r_state_p0 == DRIVE) begin
        r_an_p1  <= ~(4'b0001 << r_idx_p0);
        r_seg_p1 <= w_seg;
        r_dp_p1  <= ~r_disp_dp[r_idx_p0];
      end else begin
        r_an_p1  <= 4'hF;
        r_seg_p1 <= 7'h7F;
        r_dp_p1  <= 1'b1;
      end
    end
  end

  // r_fend_p1 marks the cycle showing the last drive cycle of digit 3
  assign w_xfer = load_valid && !r_pend_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_full <= 1'b0;
      r_disp_dig  <= '0;
      r_disp_dp   <= '0;
      r_disp_lz   <= 1'b0;
    end else if (r_fend_p1 && r_pend_full) begin
      r_pend_full <= 1'b0;
      r_disp_dig  <= r_pend_dig;
      r_disp_dp   <= r_pend_dp;
      r_disp_lz   <= r_pend_lz;
    end else if (w_xfer) begin
      r_pend_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_pend_dig <= digits_in;
      r_pend_dp  <= dp_in;
      r_pend_lz  <= blank_lz;
    end
  end

  assign load_ready     = !r_pend_full;
  assign an             = r_an_p1;
  assign segmentDisplay = r_seg_p1;
  assign dp             = r_dp_p1;
  assign frame_start    = r_fs_p1;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a frame scoreboard predicts every pin
// value of every cycle of each frame from the values offered to the handshake.
module tb_seg_scan_ctrl;

  localparam int RD    = 10;
  localparam int BC    = 2;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [27:0] seg;
    logic [3:0]  dp;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  segmentDisplay;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  int          n_cmp = 0;
  int          n_mis = 0;

  frame_t      sb[$];
  frame_t      cur;
  logic        g_offer  = 1'b0;
  logic        g_stream = 1'b0;
  logic [15:0] g_d;
  logic [3:0]  g_p;
  logic        g_lz;

  seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .digits_in      (digits_in),
    .dp_in          (dp_in),
    .blank_lz       (blank_lz),
    .segmentDisplay (segmentDisplay),
    .an             (an),
    .dp             (dp),
    .frame_start    (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #60000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  function automatic frame_t model(input logic [15:0] d, input logic [3:0] p, input logic lz);
    frame_t     f;
    logic       run;
    logic [3:0] nib;
    run = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      nib = d[k*4 +: 4];
      run = run && (nib == 4'h0);
      f.seg[k*7 +: 7] = (lz && k != 0 && run) ? 7'h7F : hex7(nib);
    end
    f.dp = p;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_dark(input string tag);
    chk(tag, 16'({an, segmentDisplay, dp}), 16'h0FFF);
    chk({tag, "_fs"}, 16'(frame_start), 16'h0000);
    chk({tag, "_rdy"}, 16'(load_ready), 16'h0001);
  endtask

  task automatic model_reset();
    sb.delete();
    cur      = model(16'h0000, 4'h0, 1'b0);
    g_offer  = 1'b0;
    g_stream = 1'b0;
  endtask

  task automatic do_cycle(input int t, input int offer_t);
    int          slot;
    int          off;
    logic [11:0] ev;
    logic        rdy;
    logic        acc;
    logic [31:0] rnd;
    slot = t / RD;
    off  = t % RD;
    if (off < BC) ev = 12'hFFF;
    else ev = {~(4'b0001 << slot), cur.seg[slot*7 +: 7], ~cur.dp[slot]};
    chk("pins", 16'({an, segmentDisplay, dp}), 16'(ev));
    chk("frame_start", 16'(frame_start), 16'(t == 0));
    rdy = (sb.size() == 0);
    chk("load_ready", 16'(load_ready), 16'(rdy));
    if (t == offer_t) g_offer = 1'b1;
    if (g_stream) begin
      rnd        = $urandom;
      load_valid = 1'b1;
      digits_in  = rnd[15:0];
      dp_in      = rnd[19:16];
      blank_lz   = rnd[20];
    end else if (g_offer) begin
      load_valid = 1'b1;
      digits_in  = g_d;
      dp_in      = g_p;
      blank_lz   = g_lz;
    end else begin
      load_valid = 1'b0;
    end
    acc = load_valid && rdy;
    if (t == FRAME - 1 && sb.size() > 0) begin
      if (load_valid) chk("simul_ready", 16'(load_ready), 16'h0000);
      cur = sb.pop_front();
    end
    if (acc) begin
      sb.push_back(model(digits_in, dp_in, blank_lz));
      g_offer = 1'b0;
    end
  endtask

  task automatic run_frame(input int offer_t, input int last_t, input bit after_rst);
    int w;
    w = 0;
    do begin
      tick();
      w++;
    end while (!frame_start && w < 100);
    if (!frame_start) begin
      chk("fs_timeout", 16'(frame_start), 16'h0001);
      return;
    end
    if (!after_rst) chk("fs_period", 16'(w), 16'h0001);
    for (int t = 0; t <= last_t; t++) begin
      if (t > 0) tick();
      do_cycle(t, offer_t);
    end
  endtask

  task automatic set_offer(input logic [15:0] d, input logic [3:0] p, input logic lz);
    g_d  = d;
    g_p  = p;
    g_lz = lz;
  endtask

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    digits_in  = 16'h0000;
    dp_in      = 4'h0;
    blank_lz   = 1'b0;
    model_reset();
    repeat (3) begin
      tick();
      chk_dark("reset");
    end
    reset_n = 1'b1;

    run_frame(-1, FRAME - 1, 1'b1);

    set_offer(16'h12AF, 4'b0100, 1'b0);
    run_frame(5, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);

    set_offer(16'h0005, 4'b0000, 1'b1);
    run_frame(3, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);
    set_offer(16'h0000, 4'b0000, 1'b1);
    run_frame(3, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);
    set_offer(16'h00F0, 4'b1000, 1'b1);
    run_frame(0, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);

    set_offer(16'h3C4D, 4'b0011, 1'b0);
    run_frame(FRAME - 1, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);
    run_frame(-1, FRAME - 1, 1'b0);

    g_stream = 1'b1;
    repeat (3) run_frame(-1, FRAME - 1, 1'b0);
    g_stream = 1'b0;
    run_frame(-1, FRAME - 1, 1'b0);

    set_offer(16'h7777, 4'b1111, 1'b0);
    run_frame(3, 6, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_dark("reset_async");
    model_reset();
    load_valid = 1'b0;
    repeat (3) begin
      tick();
      chk_dark("reset_hold");
    end
    reset_n = 1'b1;
    run_frame(-1, FRAME - 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the 4-digit, common-anode seven-segment display on the board. It time-multiplexes four hex digits onto the shared segment and decimal-point lines. It inserts a dead-time blanking interval between anode switches to suppress ghosting. New display values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the switch/value-formatting logic and the `segmentDisplay`/`an`/`dp` pins.

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range is `BLANK_CYCLES`+1 to 2^20-1.
- `BLANK_CYCLES`, 1000: cycles at the start of each slot with all anodes off; minimum 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  a new display value is offered.
- `load_ready`  out  1  the controller can accept a value.
- `digits_in`  in  16  four hex nibbles; `[3:0]` is the rightmost digit (`an[0]`).
- `dp_in`  in  4  decimal point per digit, active-high, same ordering as `digits_in`.
- `blank_lz`  in  1  enables leading-zero blanking; captured together with `digits_in`.
- `segmentDisplay`  out  7  active-low segments; bit 0 = a through bit 6 = g.
- `an`  out  4  active-low anode enables; at most one is low at any time.
- `dp`  out  1  active-low decimal point.
- `frame_start`  out  1  one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- **Registers:** `disp` (committed value, dp and lz flag), `pend` (accepted but not yet committed value), `pend_full`, slot counter, 2-bit digit index, state.
- **States:**
  - `BLANK`: `an`=1111, `segmentDisplay`=1111111, `dp`=1. After `BLANK_CYCLES` cycles, go to `DRIVE`.
  - `DRIVE`: `an` has bit[idx] low; segments and dp show `disp` digit idx. After `REFRESH_DIV`-`BLANK_CYCLES` cycles, go to `BLANK` with idx+1 (wraps 3→0).
- **Frame end:** the last `DRIVE` cycle of idx 3. If `pend_full`, copy `pend` to `disp` and clear `pend_full`.
- **Handshake:**
  - `load_ready` = !`pend_full`.
  - A transfer occurs on a cycle where `load_valid` && `load_ready`; it captures `digits_in`, `dp_in` and `blank_lz` into `pend` and sets `pend_full`.
  - A transfer on the frame-end cycle is not committed in that same cycle. It commits at the following frame end.
  - While `pend_full` is set, `load_valid` is ignored and the value is not lost: the producer holds it until `load_ready` rises.
- **Decode:** hex 0–F, active-low. Required codes:
  - 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
- **Leading-zero blanking** (when the `disp` lz flag is set):
  - Digit k (k = 3..1) is blanked (segments 1111111) if it and all higher digits are zero.
  - Digit 0 is never blanked.
  - `dp` still follows `dp_in` on blanked digits.
- **Reset:**
  - Outputs: `an`=1111, `segmentDisplay`=1111111, `dp`=1, `frame_start`=0, `load_ready`=1.
  - Internal: `disp`=0 with the lz flag clear, `pend_full`=0, idx=0, state `BLANK`, counter=0.
- **Reset mid-operation:** outputs go dark immediately (asynchronous). Any pending value is discarded.

## Timing
- All outputs are registered and change only on a rising `clk` edge (reset excepted).
- **Slot length:** exactly `REFRESH_DIV` cycles per digit. Frame period = 4×`REFRESH_DIV`.
- **After reset release:** the first `frame_start` appears on the first cycle after release. The first `an` low occurs `BLANK_CYCLES` cycles later.
- **Commit latency:** a value accepted during frame N is first displayed on idx 0's `DRIVE` in frame N+1. The worst case is just under 2 frames.
- **Ready recovery:** `load_ready` rises on the cycle after frame end.
- **Simultaneous events:** when a transfer and a commit occur in the same cycle, the old `pend` commits and `load_ready` stays low. This case cannot arise through the handshake, but the bench must assert on it.

## Structure
- **Package `seg_pkg`:**
  - `NUM_DIGITS`=4.
  - State enum `scan_state_t` {`BLANK`, `DRIVE`}.
  - The 16-entry segment code constants.
- **Sub-module `seg_decoder`:** combinational; 4-bit nibble plus blank flag in, 7-bit active-low segments out.
- Counter width is derived with `$clog2(REFRESH_DIV)`.

## Test plan
Bench parameters: `REFRESH_DIV`=10, `BLANK_CYCLES`=2.
- **Reset and first frame:** hold `reset_n` low for 3 cycles, then release → `an`=1111 for 2 cycles, then 1110 for 8 cycles with `segmentDisplay`=1000000; `frame_start` pulses every 40 cycles.
- **Load and commit:** load 16'h12AF with `dp_in`=0100 → on the next frame: digit0 shows 0001110, digit1 shows 0001000, digit2 shows 0100100 with `dp`=0, digit3 shows 1111001. `load_ready` is low from acceptance until 1 cycle after frame end.
- **Leading-zero blanking:** load 16'h0005 with `blank_lz`=1 → digits 3–1 show 1111111 and digit0 shows 0010010. Load 16'h0000 → only digit0 shows 1000000.
- **Back-pressure:** assert `load_valid` continuously with changing data → only values sampled while `load_ready`=1 are ever displayed. No frame mixes digits from two values.
- **Boundary:** transfer on the frame-end cycle → the value is not shown in the next frame, but is shown in the one after. Assert `reset_n` mid-`DRIVE` → outputs are dark in the same cycle.
